uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised, run-time configurable UART transmitter; successor to the fixed 8N1 transmitter in the UART subsystem.
- Frame format is selected per frame: 5..DBITS_MAX data bits, none/even/odd parity, 1 or 2 stop bits.
- Uses a valid/ready handshake on the input side.
- Sits between the TX FIFO (or a register-mapped source) and the tx pin; shares the oversampling baud-tick generator with the receiver.

Parameters:
DBITS_MAX, 9, widest supported data word; legal range 5..9.
OVERSAMPLE, 16, sample_tick pulses per bit period; legal range 4..32.

Ports:
clk_100MHz  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
sample_tick  input  1  one-cycle pulse from the baud generator, OVERSAMPLE per bit.
tx_valid  input  1  source has a word on data_in.
tx_ready  output  1  block can accept a word; high only in IDLE.
data_in  input  DBITS_MAX  word to send, LSB first; bits at and above cfg_dbits are ignored.
cfg_dbits  input  4  data bits per frame, 5..DBITS_MAX.
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 treated as none.
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
tx_done  output  1  one-cycle pulse at end of frame.
busy  output  1  high whenever state is not IDLE.
tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset is asynchronous, active-high, clock clk_100MHz.
  - During and after reset: state IDLE, tx=1, tx_done=0, busy=0, tx_ready=1, all counters 0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 with no partial stop bit.
- States are IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - A word is accepted on a rising edge where tx_valid && tx_ready.
  - On that edge, data_in, cfg_dbits, cfg_parity and cfg_stop2 are latched into frame registers. Config changes during a frame have no effect.
  - State goes to START and the tick counter is cleared.
- tx is registered from state. It goes low one clock after the accept edge, then follows each state with one clock of latency.
- Tick counting:
  - In every non-IDLE state, each sample_tick increments the tick counter.
  - On the OVERSAMPLE-th tick, the state advances and the counter clears.
  - A sample_tick in the accept cycle is ignored.
  - ticks in IDLE are ignored.
  - The counter width is clog2(OVERSAMPLE*2) so it covers two stop bits.
- START: tx=0 for OVERSAMPLE ticks, then go to DATA with the bit counter at 0.
- DATA:
  - tx = shift_reg[0]; shift right on each bit boundary.
  - After bit cfg_dbits-1, go to PARITY if parity is enabled, else to STOP.
- PARITY:
  - tx = XOR of the latched data bits [cfg_dbits-1:0] for even parity, the inverse for odd parity.
  - Parity is computed at accept time and stored in a 1-bit register.
- STOP:
  - tx=1 for OVERSAMPLE ticks, or 2*OVERSAMPLE ticks when stop2 is set.
  - On the final tick, go to IDLE and register tx_done=1 for exactly one cycle.
- Back-to-back frames:
  - tx_ready is high in the first IDLE cycle, the same cycle as tx_done.
  - With tx_valid held high, the next frame is accepted then, so frames are separated only by the stop bit(s) plus one clock.
- Illegal cfg_dbits values (<5 or >DBITS_MAX) are latched as DBITS_MAX.
- Frame length in ticks = OVERSAMPLE*(1 + dbits + parity_en + stop_bits).

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams;
  - the parity encodings PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - a parity function (masked XOR reduction by dbits).
- The receiver reuses the same package.
- The block is single-module; no sub-module.
- The baud generator remains a separate existing instance and is not part of this block.

Test Plan:
Bench defaults: OVERSAMPLE=16, DBITS_MAX=9, and sample_tick every 4 clocks unless stated (bit = 64 clocks).
1. 8N1, data 0x55 -> tx reads 0,1,0,1,0,1,0,1,0,1 at bit centres, each bit 64 clocks, then 1 for 64 clocks. tx_done pulses once, 640 clocks after the first low. tx_ready is low throughout.
2. 7E1, data_in 0x1C1 (bits 8:7 garbage, word 0x41) -> data 1,0,0,0,0,0,1, then parity 0, then stop. The garbage bits do not appear on tx.
3. 8O2, data 0xFF -> eight 1s, then parity 1, then stop high for 128 clocks. tx_done is asserted only after both stop bits.
4. 9N1, data 0x1A5, with sample_tick every clock -> bits 1,0,1,0,0,1,0,1,1, each 16 clocks. Frame length 176 clocks.
5. tx_valid held high with 0xA5 then 0x3C, 8N1; cfg_parity switched to odd mid-frame -> second start bit begins one clock after the first tx_done. The first frame has no parity bit; the second frame has parity 1 (0x3C has four 1s, odd parity).
6. reset asserted during bit 3 of DATA -> tx=1, busy=0, tx_ready=1, tx_done=0 with no clock edge required. After release, a fresh 0x0F 8N1 frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity encodings and the
// masked parity helper used by both the configurable transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_FN_W = 16;

    // XOR reduction over data[dbits-1:0]; bits at and above dbits are ignored.
    function automatic logic masked_parity(input logic [PAR_FN_W-1:0] data,
                                           input logic [3:0]          dbits);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < PAR_FN_W; i++) begin
            if (i < int'(dbits)) begin
                acc = acc ^ data[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter: 5..DBITS_MAX data bits, none/even/odd
// parity, 1 or 2 stop bits, with the frame format latched when a word is accepted.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBITS_MAX  = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DBITS_MAX-1:0] data_in,
    input  logic [3:0]           cfg_dbits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_done,
    output logic                 busy,
    output logic                 tx
);

    localparam int              TICK_W      = $clog2(OVERSAMPLE * 2);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST2 = TICK_W'(2 * OVERSAMPLE - 1);
    localparam logic [3:0]      DBITS_MAX_C = 4'(DBITS_MAX);

    uart_state_t          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DBITS_MAX-1:0] shift_q, shift_d;
    logic [3:0]           dbits_q, dbits_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 accept_s;
    logic [3:0]           cfg_dbits_s;
    logic                 raw_par_s;
    logic [TICK_W-1:0]    tick_limit_s;
    logic                 bit_edge_s;

    assign accept_s    = tx_valid && (state_q == ST_IDLE);
    assign cfg_dbits_s = ((cfg_dbits >= 4'd5) && (cfg_dbits <= DBITS_MAX_C)) ? cfg_dbits
                                                                            : DBITS_MAX_C;
    assign raw_par_s   = masked_parity({{(PAR_FN_W - DBITS_MAX){1'b0}}, data_in}, cfg_dbits_s);

    // The second stop bit is folded into one STOP state with a doubled tick limit.
    assign tick_limit_s = ((state_q == ST_STOP) && stop2_q) ? TICK_LAST2 : TICK_LAST;
    assign bit_edge_s   = (state_q != ST_IDLE) && sample_tick && (tick_q == tick_limit_s);

    // Next-state, frame latching and tick/bit counting.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        dbits_d   = dbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        done_d    = 1'b0;

        if (state_q != ST_IDLE && sample_tick) begin
            tick_d = bit_edge_s ? {TICK_W{1'b0}} : (tick_q + TICK_ONE);
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_START;
                    tick_d    = {TICK_W{1'b0}};
                    bit_d     = 4'd0;
                    shift_d   = data_in;
                    dbits_d   = cfg_dbits_s;
                    par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                    par_bit_d = (cfg_parity == PAR_ODD) ? ~raw_par_s : raw_par_s;
                    stop2_d   = cfg_stop2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_edge_s) begin
                    state_d = ST_DATA;
                    bit_d   = 4'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_edge_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == (dbits_q - 4'd1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_edge_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_edge_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the current state; registered so tx lags state by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_bit_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= {TICK_W{1'b0}};
            bit_q     <= 4'd0;
            shift_q   <= {DBITS_MAX{1'b0}};
            dbits_q   <= 4'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dbits_q   <= dbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx_ready = (state_q == ST_IDLE);

endmodule
